// File: rtl/gdc_pkg.sv
// Shared definitions for the garage door controller.
//   gdc_state_e : FSM state encoding
//   DIR_UP/DIR_DN : encoding of the last_dir register
package gdc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MV_UP = 3'd1,
    MV_DN = 3'd2,
    STOP  = 3'd3,
    FAULT = 3'd4
  } gdc_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/gdc_motion_timer.sv
// Saturating motion watchdog counter.
//   CLK, RST : clock, synchronous active-low reset
//   clr      : restart the count at 0 (entry into a motion state)
//   en       : count this cycle (a motor is driven)
//   timeout  : count has reached TIMEOUT_CYCLES-1, i.e. this is the last
//              permitted driven cycle
module gdc_motion_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  import gdc_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (!RST)                      count <= '0;
    else if (clr)                  count <= '0;
    else if (en && count != LAST)  count <= count + CW'(1);
  end

  assign timeout = (count == LAST);

endmodule

// File: rtl/garage_door_ctrl.sv
// Garage door controller: Moore FSM driving the up/down motor from a single
// push-button, two limit switches and an obstacle beam.
//   CLK, RST   : clock, synchronous active-low reset
//   Activate   : push-button level, only its rising edge acts
//   UP_Max     : fully-open limit switch
//   DN_Max     : fully-closed limit switch
//   Obstacle   : beam-break sensor (active high)
//   Fault_Clr  : clears the latched fault
//   UP_M, DN_M : motor drive up / down
//   Fault      : controller is in the fault state
//   Moving     : either motor driven
module garage_door_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter bit REVERSE_EN     = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic Activate,
  input  logic UP_Max,
  input  logic DN_Max,
  input  logic Obstacle,
  input  logic Fault_Clr,
  output logic UP_M,
  output logic DN_M,
  output logic Fault,
  output logic Moving
);
  import gdc_pkg::*;

  gdc_state_e state, nxt;
  logic act_q, act_pulse, lim_err, last_dir;
  logic enter_up, enter_dn, tmr_en, timeout;

  // act_q resets high so a button held through reset produces no pulse.
  assign act_pulse = Activate & ~act_q;
  assign lim_err   = UP_Max & DN_Max;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      act_q    <= 1'b1;
      last_dir <= DIR_DN;
    end else begin
      state <= nxt;
      act_q <= Activate;
      if (enter_up)      last_dir <= DIR_UP;
      else if (enter_dn) last_dir <= DIR_DN;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (act_pulse) begin
          if (lim_err)     nxt = FAULT;
          else if (UP_Max) nxt = MV_DN;
          else             nxt = MV_UP;  // closed or unknown: open first
        end
      end
      MV_UP: begin
        // Obstacle deliberately ignored while opening.
        if (lim_err)        nxt = FAULT;
        else if (UP_Max)    nxt = IDLE;
        else if (act_pulse) nxt = STOP;
        else if (timeout)   nxt = FAULT;
      end
      MV_DN: begin
        if (lim_err)        nxt = FAULT;
        else if (DN_Max)    nxt = IDLE;
        else if (Obstacle)  nxt = REVERSE_EN ? MV_UP : STOP;
        else if (act_pulse) nxt = STOP;
        else if (timeout)   nxt = FAULT;
      end
      STOP: begin
        if (act_pulse) begin
          if (lim_err)                              nxt = FAULT;
          // Resume opposite to last motion, but never close into an obstacle.
          else if (last_dir == DIR_UP && !Obstacle) nxt = MV_DN;
          else                                      nxt = MV_UP;
        end
      end
      FAULT: begin
        if (Fault_Clr) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Entry into a motion state, including the MV_DN -> MV_UP reverse.
  assign enter_up = (nxt == MV_UP) && (state != MV_UP);
  assign enter_dn = (nxt == MV_DN) && (state != MV_DN);
  assign tmr_en   = (state == MV_UP) || (state == MV_DN);

  gdc_motion_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (enter_up | enter_dn),
    .en      (tmr_en),
    .timeout (timeout)
  );

  always_comb begin
    UP_M   = (state == MV_UP);
    DN_M   = (state == MV_DN);
    Fault  = (state == FAULT);
    Moving = UP_M | DN_M;
  end

endmodule

// File: doc/garage_door_ctrl.md
# garage_door_ctrl

Second-generation automatic garage door controller: a Moore FSM that drives the up/down motor from a single push-button and two limit switches. Adds edge-detected activation, stop/resume mid-travel, obstacle auto-reverse, a motion-timeout watchdog and a latched fault state. It sits between the synchronised and debounced button/sensor inputs and the motor driver.

## Interface
- TIMEOUT_CYCLES, 1000: maximum cycles a motor may be driven before a fault is declared; must be ≥ 2.
- REVERSE_EN, 1: 1 = obstacle during closing reverses to MV_UP; 0 = obstacle stops the door (STOP).
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-low.
- Activate  in  1  push-button level, already synchronous to CLK; only its rising edge acts.
- UP_Max  in  1  door fully open limit switch.
- DN_Max  in  1  door fully closed limit switch.
- Obstacle  in  1  beam-break sensor, level, active-high.
- Fault_Clr  in  1  clears FAULT; level, sampled each cycle.
- UP_M  out  1  drive motor up.
- DN_M  out  1  drive motor down.
- Fault  out  1  controller is in FAULT.
- Moving  out  1  UP_M | DN_M.

## Operation
- act_pulse = Activate & !act_q; act_q is a register of Activate, reset to 1, so a button held through reset gives no pulse.
- last_dir register: 1 = last motion was up, 0 = down. It resets to 0 and updates on entry to MV_UP or MV_DN.
- lim_err = UP_Max & DN_Max.
- States: IDLE, MV_UP, MV_DN, STOP, FAULT. Reset state is IDLE.
- IDLE: motors off.
  - On act_pulse: lim_err → FAULT; UP_Max → MV_DN; DN_Max → MV_UP; neither limit → MV_UP (unknown position, open first).
  - Without act_pulse, stay in IDLE.
- MV_UP: UP_M=1. Priority order:
  - lim_err → FAULT
  - UP_Max → IDLE
  - act_pulse → STOP
  - timeout → FAULT
  - else stay.
  - Obstacle is ignored while opening.
- MV_DN: DN_M=1. Priority order:
  - lim_err → FAULT
  - DN_Max → IDLE
  - Obstacle → MV_UP if REVERSE_EN, else STOP
  - act_pulse → STOP
  - timeout → FAULT
  - else stay.
- STOP: motors off.
  - On act_pulse: lim_err → FAULT; otherwise move opposite to last_dir (last_dir=1 → MV_DN, 0 → MV_UP).
  - Exception: if last_dir=1 and Obstacle=1, go to MV_UP instead; the door never closes into an obstacle.
- FAULT: motors off, Fault=1.
  - Fault_Clr=1 → IDLE. act_pulse is ignored.
- Outputs are a pure decode of the current state: UP_M=(MV_UP), DN_M=(MV_DN), Fault=(FAULT). UP_M and DN_M are never both 1.
- Motion timer:
  - Cleared on every transition into MV_UP or MV_DN, including the reverse from MV_DN to MV_UP.
  - Increments each cycle in a motion state and saturates.
  - timeout = (count == TIMEOUT_CYCLES-1), so a motor is driven for at most TIMEOUT_CYCLES cycles.
  - Width is $clog2(TIMEOUT_CYCLES).

## Timing
- Reset values: UP_M=0, DN_M=0, Fault=0, Moving=0, state=IDLE, count=0, last_dir=0, act_q=1.
- Latency: Activate sampled high at edge k (previously low) → state change and motor output at edge k+1.
  - Limit, obstacle and Fault_Clr responses are also 1 cycle.
- A second act_pulse needs Activate to go low and then high again; there is no minimum low width beyond 1 cycle.
- Reset asserted mid-motion: motors off at the next edge; timer and last_dir are cleared.
- A limit switch already asserted on entry to its own motion state exits on the next cycle, so the motor pulses for 1 cycle.

## Structure
- Shared package gdc_pkg holds:
  - the state enum (3-bit, values IDLE=0, MV_UP=1, MV_DN=2, STOP=3, FAULT=4);
  - localparam DIR_UP=1'b1 / DIR_DN=1'b0.
- One sub-module, gdc_motion_timer (parameter TIMEOUT_CYCLES):
  - inputs: clr, en;
  - output: timeout;
  - holds the saturating counter.
- The FSM, edge detector and last_dir register stay in the top module.

## Test plan
- Closed door, open fully: DN_Max=1, Activate pulse → UP_M=1 the next cycle. Raise UP_Max after 50 cycles → IDLE, UP_M=0, last_dir=1.
- Stop and resume: open door, start MV_DN, act_pulse after 20 cycles → STOP with motors off. Next act_pulse → MV_UP (opposite of down).
- Obstacle with REVERSE_EN=1: during MV_DN assert Obstacle → UP_M=1 and DN_M=0 the next cycle, timer restarted at 0. With REVERSE_EN=0 → STOP.
- Timeout: TIMEOUT_CYCLES=16, start MV_UP with no limit reached → UP_M high for exactly 16 cycles, then Fault=1. act_pulse is ignored; Fault_Clr=1 → IDLE.
- Limit conflict: UP_Max=DN_Max=1 in IDLE plus act_pulse → FAULT. The same conflict during MV_DN → FAULT within 1 cycle.
- Reset: Activate held high across RST release → no motion. RST low during MV_UP → UP_M=0 at the next edge.
